// File: rtl/arith_pipe.sv
// arith_pipe: pipelined two's-complement adder/subtractor with valid/ready
// handshaking. The operands are split into STAGES segments of WIDTH/STAGES
// bits. One segment is resolved per register rank, and the carry is
// registered between segments. The last rank is the output register.
//
// Optional feature: define ARITH_SAT_EN to clamp the result on signed
// overflow when the transaction's `sat` bit is set. Without it, `sat` is
// carried along but ignored, and the result wraps.

module arith_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             add_sub,
  input  logic             sat,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [TAG_W-1:0] tag_out
);

  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0 || TAG_W < 1) begin : g_param_check
    $error("arith_pipe: WIDTH must be a multiple of STAGES (1..WIDTH) and TAG_W >= 1");
  end

  // Inputs seen by each stage's segment adder. Index 0 comes straight from
  // the ports. Index k>0 comes from the register rank written by stage k-1.
  logic [WIDTH-1:0] st_x   [STAGES];
  logic [WIDTH-1:0] st_y   [STAGES];
  logic [WIDTH-1:0] st_res [STAGES];
  logic             st_c   [STAGES];
  logic             st_z   [STAGES];
  logic             st_v   [STAGES];
  logic             st_sat [STAGES];
  logic [TAG_W-1:0] st_tag [STAGES];

  logic             adv;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             overflow_q;
  logic             zero_q;
  logic             negative_q;
  logic [TAG_W-1:0] tag_q;

  // One enable for the whole pipe: it moves unless the output slot is held.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Stage 0 view. y is pre-inverted for subtract, and the carry-in completes
  // the two's-complement negation.
  assign st_x[0]   = x;
  assign st_y[0]   = y ^ {WIDTH{add_sub}};
  assign st_c[0]   = add_sub;
  assign st_res[0] = '0;
  assign st_z[0]   = 1'b1;
  assign st_v[0]   = in_valid;
  assign st_sat[0] = sat;
  assign st_tag[0] = tag_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] res_d;
    logic             z_d;

    // Resolve segment k. Merge it into the partial result and the running zero-AND.
    always_comb begin
      seg_sum = {1'b0, st_x[k][k*SEG +: SEG]}
              + {1'b0, st_y[k][k*SEG +: SEG]}
              + {{SEG{1'b0}}, st_c[k]};
      res_d = st_res[k];
      res_d[k*SEG +: SEG] = seg_sum[SEG-1:0];
      z_d = st_z[k] && (seg_sum[SEG-1:0] == '0);
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] x_q;
      logic [WIDTH-1:0] y_q;
      logic [WIDTH-1:0] res_q;
      logic             c_q;
      logic             z_q;
      logic             v_q;
      logic             sat_q;
      logic [TAG_W-1:0] tag_mid_q;

      // Inter-stage rank. It carries the skewed operands, the carry, the lower result bits and the tag.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q       <= '0;
          y_q       <= '0;
          res_q     <= '0;
          c_q       <= 1'b0;
          z_q       <= 1'b0;
          v_q       <= 1'b0;
          sat_q     <= 1'b0;
          tag_mid_q <= '0;
        end else if (adv) begin
          x_q       <= st_x[k];
          y_q       <= st_y[k];
          res_q     <= res_d;
          c_q       <= seg_sum[SEG];
          z_q       <= z_d;
          v_q       <= st_v[k];
          sat_q     <= st_sat[k];
          tag_mid_q <= st_tag[k];
        end
      end

      assign st_x[k+1]   = x_q;
      assign st_y[k+1]   = y_q;
      assign st_res[k+1] = res_q;
      assign st_c[k+1]   = c_q;
      assign st_z[k+1]   = z_q;
      assign st_v[k+1]   = v_q;
      assign st_sat[k+1] = sat_q;
      assign st_tag[k+1] = tag_mid_q;
    end else begin : g_last
      logic             x_msb;
      logic             ovf_d;
      logic             sat_hit;
      logic [WIDTH-1:0] result_d;
      logic             zero_d;
      logic             neg_d;

      // Signed overflow: both addends share a sign that the raw sum does not.
      // This is the same as carry-into-MSB XOR carry-out-of-MSB, but it does
      // not need a split adder when SEG is 1.
      assign x_msb = st_x[k][WIDTH-1];
      assign ovf_d = (x_msb == st_y[k][WIDTH-1]) && (res_d[WIDTH-1] != x_msb);

`ifdef ARITH_SAT_EN
      assign sat_hit = st_sat[k] && ovf_d;
`else
      logic unused_sat;
      assign unused_sat = st_sat[k];
      assign sat_hit    = 1'b0;
`endif

      // Final result. A clamp is never zero, so the running zero-AND is used only when unclamped.
      always_comb begin
        result_d = res_d;
        zero_d   = z_d;
        if (sat_hit) begin
          result_d = {x_msb, {(WIDTH-1){!x_msb}}};
          zero_d   = 1'b0;
        end
        neg_d = result_d[WIDTH-1];
      end

      // Output rank. Every result output comes from here, and all of it holds while stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          result_q    <= '0;
          cout_q      <= 1'b0;
          overflow_q  <= 1'b0;
          zero_q      <= 1'b0;
          negative_q  <= 1'b0;
          tag_q       <= '0;
        end else if (adv) begin
          out_valid_q <= st_v[k];
          result_q    <= result_d;
          cout_q      <= seg_sum[SEG];
          overflow_q  <= ovf_d;
          zero_q      <= zero_d;
          negative_q  <= neg_d;
          tag_q       <= st_tag[k];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign tag_out   = tag_q;

endmodule

// File: tb/tb_arith_pipe.sv
// Directed and randomised checks for arith_pipe (WIDTH=32, STAGES=4).
module tb_arith_pipe;

  localparam int WIDTH     = 32;
  localparam int STAGES_TB = 4;
  localparam int TAG_W     = 4;
  localparam int N_RND     = 200;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             add_sub = 1'b0;
  logic             sat = 1'b0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic [TAG_W-1:0] tag_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arith_pipe #(.WIDTH(WIDTH), .STAGES(STAGES_TB), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .add_sub(add_sub), .sat(sat), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .overflow(overflow), .zero(zero), .negative(negative),
    .tag_out(tag_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {result, cout, overflow, zero, negative, tag}
  function automatic logic [39:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic as, input logic s, input logic [3:0] tg);
    logic [31:0] bb;
    logic [32:0] full;
    logic [31:0] r;
    logic        ovf;
    logic        unused_s;
    unused_s = s;
    bb   = as ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, as};
    r    = full[31:0];
    ovf  = (a[31] == bb[31]) && (r[31] != a[31]);
`ifdef ARITH_SAT_EN
    if (s && ovf) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {r, full[32], ovf, (r == 32'd0), r[31], tg};
  endfunction

  // Call at posedge+1 with an empty pipe. Sends one op and checks latency, result, flags and drain.
  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic as, input logic s, input logic [3:0] tg,
                         input logic [31:0] er, input logic ec, input logic eo,
                         input logic ez, input logic en);
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; x = a; y = b; add_sub = as; sat = s; tag_in = tg;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(STAGES_TB));
    chk({name, "_res"}, {32'd0, result}, {32'd0, er});
    chk({name, "_flags"}, {56'd0, cout, overflow, zero, negative, tag_out},
        {56'd0, ec, eo, ez, en, tg});
    @(posedge clk); #1;
    chk({name, "_drain"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin : main
    logic [39:0] exp_q[$];
    logic [31:0] px, py;
    logic        pas, ps, have;
    int          sent, got_n, cyc, stale;

    // Reset state
    #2;
    chk("rst_outs", {24'd0, out_valid, result, cout, overflow, zero, negative, tag_out}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);

    // Directed vectors
    run_vec("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h3,
            32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec("sub_5_7", 32'd5, 32'd7, 1'b1, 1'b0, 4'h4,
            32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_vec("sub_7_5", 32'd7, 32'd5, 1'b1, 1'b0, 4'h5,
            32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef ARITH_SAT_EN
    run_vec("sat_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 4'h6,
            32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    run_vec("sat_neg", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 4'h7,
            32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    run_vec("sat_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 4'h6,
            32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_vec("sat_neg", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 4'h7,
            32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    run_vec("seg_carry", 32'h1234_5678, 32'h0000_FFFF, 1'b0, 1'b0, 4'h8,
            32'h1235_5677, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("sub_zero", 32'd0, 32'd0, 1'b1, 1'b0, 4'h9,
            32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'hA,
            32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0);

    // Fill the pipe, then reset mid-cycle
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; x = 32'(i + 1); y = 32'(i + 1); add_sub = 1'b0; sat = 1'b0;
      tag_in = 4'(i + 8);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("fill_out", {23'd0, out_valid, result, tag_out, 4'd0}, {23'd0, 1'b1, 32'd2, 4'd8, 4'd0});
    #4;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {24'd0, out_valid, result, cout, overflow, zero, negative, tag_out}, 64'd0);
    chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("rst_no_stale", 64'(stale), 64'd0);

    // Random back-to-back traffic with pseudo-random backpressure
    sent = 0; got_n = 0; cyc = 0; have = 1'b0;
    px = '0; py = '0; pas = 1'b0; ps = 1'b0;
    while (got_n < N_RND && cyc < 5000) begin
      out_ready = ($urandom_range(0, 9) < 6);
      if (!have && sent < N_RND && $urandom_range(0, 7) != 0) begin
        px = $urandom; py = $urandom;
        pas = 1'($urandom_range(0, 1)); ps = 1'($urandom_range(0, 1));
        have = 1'b1;
      end
      in_valid = have; x = px; y = py; add_sub = pas; sat = ps; tag_in = 4'(sent % 16);
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious", {63'd0, out_valid}, 64'd0);
        end else begin
          chk($sformatf("rnd_out%0d", got_n),
              {24'd0, result, cout, overflow, zero, negative, tag_out}, {24'd0, exp_q[0]});
        end
        if (out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          got_n++;
        end
      end
      chk("rnd_in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (in_valid && in_ready) begin
        exp_q.push_back(model(px, py, pas, ps, 4'(sent % 16)));
        sent++;
        have = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_count", 64'(got_n), 64'(N_RND));
    chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
